// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: opcodes, descriptor kind codes and loader FSM states.
// Imported by the encoder/loader and the control decoder so both agree on encodings.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] KIND_RTYPE = 3'd0;
  localparam logic [2:0] KIND_LW    = 3'd1;
  localparam logic [2:0] KIND_SW    = 3'd2;
  localparam logic [2:0] KIND_BEQ   = 3'd3;
  localparam logic [2:0] KIND_ADDI  = 3'd4;
  localparam logic [2:0] KIND_J     = 3'd5;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

endpackage

// File: rtl/instr_encode.sv
// Combinational encoder: packs a field-level descriptor into a 32-bit MIPS word.
// Kinds outside the supported subset raise illegal and produce a zero word.
module instr_encode
  import mips_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (kind)
      KIND_RTYPE: word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
      KIND_LW:    word = {OP_LW, rs, rt, imm};
      KIND_SW:    word = {OP_SW, rs, rt, imm};
      KIND_BEQ:   word = {OP_BEQ, rs, rt, imm};
      KIND_ADDI:  word = {OP_ADDI, rs, rt, imm};
      KIND_J:     word = {OP_J, target};
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams encoded instructions into instruction memory and holds the core in reset
// until a complete program has been written.
module instr_encoder_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] BASE    = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] TOP_PTR = '1;

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] next_addr;
  logic              we_q;
  logic              last_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word;
  logic              illegal;
  logic              accept;

  instr_encode u_encode (
    .kind    (in_kind),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .funct   (in_funct),
    .imm     (in_imm),
    .target  (in_target),
    .word    (word),
    .illegal (illegal)
  );

  assign accept = in_valid & in_ready;

  // ptr tracks the address of the write currently on the port; a descriptor
  // accepted while a write is in flight lands on the following address.
  assign next_addr = ptr + ADDR_W'(we_q);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= ST_LOAD;
      ptr     <= BASE;
      we_q    <= 1'b0;
      last_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      we_q <= 1'b0;
      if (we_q && ptr != TOP_PTR)
        ptr <= ptr + ADDR_W'(1);
      case (state)
        ST_LOAD: begin
          if (accept) begin
            if (illegal) begin
              state <= ST_ERR;
            end else begin
              we_q    <= 1'b1;
              wdata_q <= word;
              last_q  <= in_last;
              if (in_last || next_addr == TOP_PTR)
                state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: state <= last_q ? ST_DONE : ST_ERR;
        ST_DONE, ST_ERR: begin
          if (reload) begin
            state <= ST_LOAD;
            ptr   <= BASE;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  assign in_ready   = (state == ST_LOAD);
  assign imem_we    = we_q;
  assign imem_addr  = ptr;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = (state != ST_DONE);
  assign done       = (state == ST_DONE);
  assign error      = (state == ST_ERR);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader: a default 64-word instance
// and a 4-word instance for the full/overflow boundary.
module tb_instr_encoder_loader;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        in_valid, in_valid2;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;
  logic        reload, reload2;

  logic        in_ready, imem_we, cpu_hold, done, error;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        in_ready2, imem_we2, cpu_hold2, done2, error2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_wdata2;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  instr_encoder_loader #(.ADDR_W(6), .BASE_ADDR(0)) dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .in_last(in_last), .reload(reload), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .in_last(in_last), .reload(reload2), .imem_we(imem_we2),
    .imem_addr(imem_addr2), .imem_wdata(imem_wdata2), .cpu_hold(cpu_hold2),
    .done(done2), .error(error2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] kind, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic [5:0] funct, input logic [15:0] imm,
                               input logic [25:0] target, input logic last);
    in_kind   = kind;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_funct  = funct;
    in_imm    = imm;
    in_target = target;
    in_last   = last;
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; reload = 1'b0; reload2 = 1'b0;
    applyStimulus(3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
    step();
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_we", 32'(imem_we), 32'd0);
    checkOutput("rst_addr", 32'(imem_addr), 32'd0);
    checkOutput("rst_wdata", imem_wdata, 32'd0);
    checkOutput("rst_hold", 32'(cpu_hold), 32'd1);
    checkOutput("rst_done_err", {30'd0, done, error}, 32'd0);
    RESET = 1'b0;

    // Single RTYPE write
    applyStimulus(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checkOutput("rtype_we", 32'(imem_we), 32'd1);
    checkOutput("rtype_addr", 32'(imem_addr), 32'd0);
    checkOutput("rtype_wdata", imem_wdata, 32'h00221820);
    checkOutput("rtype_ready", 32'(in_ready), 32'd1);
    step();
    checkOutput("rtype_we_drop", 32'(imem_we), 32'd0);

    RESET = 1'b1; step(); RESET = 1'b0;

    // Back-to-back program LW, ADDI, J(last)
    in_valid = 1'b1;
    applyStimulus(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0);
    step();
    checkOutput("lw_addr", 32'(imem_addr), 32'd0);
    checkOutput("lw_wdata", imem_wdata, 32'h8C080004);
    applyStimulus(3'd4, 5'd8, 5'd9, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0);
    step();
    checkOutput("addi_we", 32'(imem_we), 32'd1);
    checkOutput("addi_addr", 32'(imem_addr), 32'd1);
    checkOutput("addi_wdata", imem_wdata, 32'h2109FFFF);
    applyStimulus(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b1);
    step();
    in_valid = 1'b0;
    checkOutput("j_addr", 32'(imem_addr), 32'd2);
    checkOutput("j_wdata", imem_wdata, 32'h08000010);
    checkOutput("drain_ready", 32'(in_ready), 32'd0);
    checkOutput("drain_hold", 32'(cpu_hold), 32'd1);
    step();
    checkOutput("done_flag", 32'(done), 32'd1);
    checkOutput("done_hold", 32'(cpu_hold), 32'd0);
    checkOutput("done_we", 32'(imem_we), 32'd0);
    step();
    checkOutput("done_sticky", {30'd0, done, error}, 32'd2);

    // Reload from DONE, then illegal kind at addr 2 with reload ignored mid-stream
    reload = 1'b1; step(); reload = 1'b0;
    checkOutput("reload_ready", 32'(in_ready), 32'd1);
    checkOutput("reload_addr", 32'(imem_addr), 32'd0);
    checkOutput("reload_hold", 32'(cpu_hold), 32'd1);
    in_valid = 1'b1;
    applyStimulus(3'd2, 5'd4, 5'd5, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b0);
    step();
    checkOutput("sw_wdata", imem_wdata, 32'hAC850010);
    applyStimulus(3'd3, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFE, 26'd0, 1'b0);
    reload = 1'b1;
    step();
    reload = 1'b0;
    checkOutput("beq_addr_reload_ignored", 32'(imem_addr), 32'd1);
    checkOutput("beq_wdata", imem_wdata, 32'h1022FFFE);
    applyStimulus(3'd6, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
    step();
    in_valid = 1'b0;
    checkOutput("ill_we", 32'(imem_we), 32'd0);
    checkOutput("ill_ready", 32'(in_ready), 32'd0);
    checkOutput("ill_flags", {29'd0, cpu_hold, done, error}, 32'b101);
    checkOutput("ill_addr", 32'(imem_addr), 32'd2);
    step();
    checkOutput("ill_no_write", 32'(imem_we), 32'd0);
    reload = 1'b1; step(); reload = 1'b0;
    checkOutput("err_reload_flags", {29'd0, in_ready, done, error}, 32'b100);
    checkOutput("err_reload_addr", 32'(imem_addr), 32'd0);

    // Reload during DRAIN is ignored
    in_valid = 1'b1;
    applyStimulus(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h3FFFFFF, 1'b1);
    step();
    in_valid = 1'b0;
    checkOutput("j_max_wdata", imem_wdata, 32'h0BFFFFFF);
    reload = 1'b1; step(); reload = 1'b0;
    checkOutput("drain_reload_done", {30'd0, done, error}, 32'd2);

    // Reset mid-stream at addr 5
    reload = 1'b1; step(); reload = 1'b0;
    in_valid = 1'b1;
    applyStimulus(3'd4, 5'd1, 5'd1, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b0);
    for (int i = 0; i < 6; i++) step();
    checkOutput("stream_addr5", 32'(imem_addr), 32'd5);
    checkOutput("stream_we5", 32'(imem_we), 32'd1);
    RESET = 1'b1;
    #1;
    checkOutput("async_rst_we", 32'(imem_we), 32'd0);
    checkOutput("async_rst_ready", 32'(in_ready), 32'd1);
    checkOutput("async_rst_addr", 32'(imem_addr), 32'd0);
    step();
    RESET = 1'b0;
    step();
    in_valid = 1'b0;
    checkOutput("post_rst_addr", 32'(imem_addr), 32'd0);
    checkOutput("post_rst_we", 32'(imem_we), 32'd1);
    step();

    // 4-word memory: full program then overflow
    in_valid2 = 1'b1;
    applyStimulus(3'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0002, 26'd0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    checkOutput("full_addr2", 32'(imem_addr2), 32'd2);
    in_last = 1'b1;
    step();
    in_valid2 = 1'b0;
    checkOutput("full_addr3", 32'(imem_addr2), 32'd3);
    checkOutput("full_wdata3", imem_wdata2, 32'h20010002);
    checkOutput("full_ready", 32'(in_ready2), 32'd0);
    step();
    checkOutput("full_done", {29'd0, cpu_hold2, done2, error2}, 32'b010);
    reload2 = 1'b1; step(); reload2 = 1'b0;
    in_valid2 = 1'b1;
    in_last = 1'b0;
    for (int i = 0; i < 4; i++) step();
    in_valid2 = 1'b0;
    checkOutput("ovf_we3", {29'd0, imem_we2, imem_addr2}, 32'b111);
    checkOutput("ovf_ready", 32'(in_ready2), 32'd0);
    step();
    checkOutput("ovf_err", {29'd0, cpu_hold2, done2, error2}, 32'b101);
    checkOutput("ovf_no_wrap", 32'(imem_addr2), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encodes field-level instruction descriptors into 32-bit MIPS words for the subset our control decoder supports: R-type, LW, SW, BEQ, ADDI, J.
- Writes the encoded words sequentially into instruction memory through a registered write port.
- Holds the processor in reset (cpu_hold) until a program has been fully loaded.
- Sits between the host/test feeder and the instruction-memory write port, in front of the single-cycle core.

Parameters:
ADDR_W, 6, word-address width of instruction memory (2^ADDR_W words)
BASE_ADDR, 0, first word address written after reset or reload

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-high reset
in_valid  in  1  descriptor present
in_ready  out  1  block can accept a descriptor this cycle
in_kind  in  3  0=RTYPE 1=LW 2=SW 3=BEQ 4=ADDI 5=J; 6,7 illegal
in_rs  in  5  source register
in_rt  in  5  target register
in_rd  in  5  destination register (RTYPE only)
in_funct  in  6  function field (RTYPE only)
in_imm  in  16  immediate/offset (LW, SW, BEQ, ADDI)
in_target  in  26  jump target (J)
in_last  in  1  descriptor is the final word of the program
reload  in  1  single-cycle pulse; restart loading from BASE_ADDR
imem_we  out  1  instruction-memory write enable
imem_addr  out  ADDR_W  write word address
imem_wdata  out  32  encoded instruction
cpu_hold  out  1  1 = core held in reset
done  out  1  program loaded successfully
error  out  1  illegal kind or memory overflow

Behaviour:
- Reset: all outputs clear except the following.
  - State = LOAD; write pointer = BASE_ADDR.
  - Outputs: in_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=1, done=0, error=0.
- Encoding (opcodes fixed; put them in the shared package):
  - RTYPE = {6'b000000, rs, rt, rd, 5'b0, funct}
  - LW = {6'b100011, rs, rt, imm}
  - SW = {6'b101011, rs, rt, imm}
  - BEQ = {6'b000100, rs, rt, imm}
  - ADDI = {6'b001000, rs, rt, imm}
  - J = {6'b000010, target}
  - Fields unused by a kind are ignored.
- Handshake: a descriptor is accepted on any rising edge with in_valid & in_ready. The feeder must hold inputs stable while in_valid=1 and in_ready=0.
- Latency: a descriptor accepted at edge k produces imem_we=1, imem_addr=ptr and imem_wdata=encoded for exactly the cycle following edge k.
  - ptr increments at edge k+1.
  - Back-to-back accepts produce one write per cycle.
- States:
  - LOAD: in_ready=1, cpu_hold=1.
    - Accept with legal kind, in_last=0, ptr < max → stay in LOAD.
    - Accept with legal kind and (in_last=1, or ptr = 2^ADDR_W-1) → DRAIN.
    - Accept with illegal kind → ERR. No write occurs; the pointer is unchanged.
  - DRAIN: in_ready=0; the final write is in flight. Next state is DONE if the final descriptor had in_last=1, otherwise ERR (overflow).
  - DONE: in_ready=0, cpu_hold=0, done=1.
  - ERR: in_ready=0, cpu_hold=1, error=1.
- Pointer rules:
  - The pointer never wraps.
  - A write to the top address that carries in_last=1 is a legal full program → DONE.
  - A write to the top address without in_last → overflow → ERR; that final word is still written.
- Reload:
  - In DONE or ERR: next state LOAD, ptr=BASE_ADDR, done/error cleared, cpu_hold=1 from the next cycle.
  - Ignored in LOAD and DRAIN.
- RESET mid-load: returns immediately to the reset state. Any in-flight imem_we is dropped asynchronously; the partially written memory contents are not cleared.
- done and error are never both 1.
- cpu_hold deasserts only in DONE.

Decomposition:
- Shared package (mips_pkg): opcode localparams OP_RTYPE/OP_LW/OP_SW/OP_BEQ/OP_ADDI/OP_J, the in_kind code constants, and FSM state encodings. Shared with the control decoder so that encoder and decoder cannot diverge.
- One natural sub-module: instr_encode, purely combinational. It takes kind plus fields and returns word[31:0] and an illegal flag. The top module holds the FSM, pointer and output registers.

Test Plan:
- Reset then RTYPE rs=1 rt=2 rd=3 funct=6'h20, last=0 → next cycle imem_we=1, addr=0, wdata=32'h00221820; in_ready stays 1.
- Stream LW(rs=0,rt=8,imm=4), ADDI(rs=8,rt=9,imm=16'hFFFF), J(target=26'h10) last=1, back-to-back → writes at addr 0..2 = 32'h8C080004, 32'h2109FFFF, 32'h08000010 on consecutive cycles; done=1 and cpu_hold=0 two cycles after the last accept.
- Kind=6 at addr 2 → no write, in_ready=0, error=1, cpu_hold=1, done=0; then reload pulse → LOAD at addr 0, error=0.
- ADDR_W=2: four legal descriptors, the 4th with last=1 → DONE. Repeat with the 4th last=0 → word at addr 3 written, then ERR.
- Assert RESET while in_valid streaming at addr 5 → imem_we=0 and in_ready=1 immediately; the next accepted descriptor is written to addr 0.
- reload pulsed in LOAD mid-stream and in DRAIN → ignored; ptr continues and done asserts normally.
